// File: rtl/iact_sram_read_scheduler.sv
// iact data SRAM sequencer: fill phases plus round-robin shared reads
// of zero-terminated CSC streams through a 4-entry skid FIFO.
module iact_sram_read_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 10,
    parameter int DATA_W  = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fill_req,
    output logic                     fill_busy,
    output logic                     sram_write_en,
    input  logic                     sram_write_done,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_stream,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     sram_read_en,
    output logic [IDX_W-1:0]         sram_read_addr,
    output logic                     sram_data_out_ready,
    input  logic                     sram_data_out_valid,
    input  logic [DATA_W-1:0]        sram_data_out,
    input  logic                     sram_read_done,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ-1:0]       rsp_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READ,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   stream_q, stream_d;
    logic               issued_q, issued_d;
    logic [DATA_W-1:0]  mem_q [4];
    logic [DATA_W-1:0]  mem_d [4];
    logic [1:0]         wr_q, wr_d;
    logic [1:0]         rd_q, rd_d;
    logic [2:0]         count_q, count_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_stream;
    logic [NUM_REQ-1:0] gmask;
    logic               push;
    logic               pop;

    // First pending requester at or above the RR pointer, with wrap.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!pick_found && req_valid[PTR_W'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    always_comb begin
        pick_stream = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_stream = req_stream[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        rr_d                = rr_q;
        stream_d            = stream_q;
        mem_d               = mem_q;
        wr_d                = wr_q;
        rd_d                = rd_q;
        count_d             = count_q;
        issued_d            = 1'b0;
        push                = 1'b0;
        pop                 = 1'b0;
        req_ready           = '0;
        fill_busy           = 1'b0;
        sram_write_en       = 1'b0;
        sram_read_en        = 1'b0;
        sram_data_out_ready = 1'b0;
        rsp_valid           = '0;
        rsp_done            = '0;
        gmask               = NUM_REQ'(1) << grant_q;

        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d = FILL;
                end else if (pick_found && !reset) begin
                    req_ready = NUM_REQ'(1) << pick_idx;
                    grant_d   = pick_idx;
                    stream_d  = pick_stream;
                    state_d   = READ;
                end
            end
            FILL: begin
                fill_busy     = 1'b1;
                sram_write_en = 1'b1;
                if (sram_write_done) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                sram_read_en = 1'b1;
                // One read may still be in flight, so leave room for it.
                sram_data_out_ready =
                    ({1'b0, count_q} + 4'(issued_q)) < 4'd3;
                push = sram_data_out_valid && (sram_data_out != '0);
                if (sram_read_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == 3'd0) begin
                    rsp_done = gmask;
                    rr_d     = (grant_q == PTR_W'(NUM_REQ - 1))
                             ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == READ || state_q == DRAIN) begin
            if (count_q != 3'd0) begin
                rsp_valid = gmask;
                pop       = rsp_ready[grant_q];
            end
        end

        issued_d = sram_read_en & sram_data_out_ready;

        if (push) begin
            mem_d[wr_q] = sram_data_out;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
        count_d = count_q + 3'(push) - 3'(pop);
    end

    assign sram_read_addr = stream_q;
    assign rsp_data       = (count_q != 3'd0) ? mem_q[rd_q] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            stream_q <= '0;
            issued_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            stream_q <= stream_d;
            issued_q <= issued_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_iact_sram_read_scheduler.sv
// Bench for iact_sram_read_scheduler: directed timing steps followed by
// randomized traffic against a stream-level model of arbitration and data.
module tb_iact_sram_read_scheduler;

    localparam int N  = 3;
    localparam int IW = 10;
    localparam int DW = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic              fill_req;
    logic              fill_busy;
    logic              sram_write_en;
    logic              sram_write_done;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_stream;
    logic [N-1:0]      req_ready;
    logic              sram_read_en;
    logic [IW-1:0]     sram_read_addr;
    logic              sram_data_out_ready;
    logic              sram_data_out_valid;
    logic [DW-1:0]     sram_data_out;
    logic              sram_read_done;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [N-1:0]      rsp_ready;
    logic [N-1:0]      rsp_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    iact_sram_read_scheduler #(
        .NUM_REQ(N),
        .IDX_W  (IW),
        .DATA_W (DW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .fill_req           (fill_req),
        .fill_busy          (fill_busy),
        .sram_write_en      (sram_write_en),
        .sram_write_done    (sram_write_done),
        .req_valid          (req_valid),
        .req_stream         (req_stream),
        .req_ready          (req_ready),
        .sram_read_en       (sram_read_en),
        .sram_read_addr     (sram_read_addr),
        .sram_data_out_ready(sram_data_out_ready),
        .sram_data_out_valid(sram_data_out_valid),
        .sram_data_out      (sram_data_out),
        .sram_read_done     (sram_read_done),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_ready          (rsp_ready),
        .rsp_done           (rsp_done)
    );

    // SRAM read port: one word per accepted read, a cycle later.
    logic [DW-1:0] smem [32][16];
    logic [3:0]    spos;

    always @(posedge clock) begin
        if (reset || !sram_read_en) begin
            spos                <= '0;
            sram_data_out_valid <= 1'b0;
            sram_read_done      <= 1'b0;
            sram_data_out       <= '0;
        end else if (sram_data_out_ready) begin
            sram_data_out       <= smem[sram_read_addr[4:0]][spos];
            sram_data_out_valid <= 1'b1;
            sram_read_done      <= (smem[sram_read_addr[4:0]][spos] == '0);
            if (spos != 4'd15) spos <= spos + 4'd1;
        end else begin
            sram_data_out_valid <= 1'b0;
            sram_read_done      <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    task automatic chk_outs(input string t);
        chk({t, "_fill_busy"}, fill_busy, 0);
        chk({t, "_write_en"}, sram_write_en, 0);
        chk({t, "_req_ready"}, req_ready, 0);
        chk({t, "_read_en"}, sram_read_en, 0);
        chk({t, "_read_addr"}, sram_read_addr, 0);
        chk({t, "_dout_ready"}, sram_data_out_ready, 0);
        chk({t, "_rsp_valid"}, rsp_valid, 0);
        chk({t, "_rsp_data"}, rsp_data, 0);
        chk({t, "_rsp_done"}, rsp_done, 0);
    endtask

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (((v >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        if (i < 0) return '0;
        return N'(1) << i;
    endfunction

    logic [DW-1:0] expq[$];

    // A stream delivers exactly its words ahead of the first zero.
    task automatic load_exp(input int s);
        expq.delete();
        for (int k = 0; k < 16; k++) begin
            if (smem[s][k] == '0) break;
            expq.push_back(smem[s][k]);
        end
    endtask

    initial begin
        int            s5[3];
        int            order[$];
        logic [DW-1:0] got[$];
        bit            done;
        int            p;
        bit            busy;
        int            g;
        bit            pend[N];
        int            pst[N];
        logic [N-1:0]  exp_rr;
        logic [N-1:0]  own;
        int            pk;
        int            cyc;
        bit            anyp;

        s5[0] = 3; s5[1] = 7; s5[2] = 9;
        reset = 1'b1;
        fill_req = 1'b0;
        sram_write_done = 1'b0;
        req_valid = '0;
        req_stream = '0;
        rsp_ready = '0;

        for (int s = 0; s < 32; s++) begin
            int len;
            len = $urandom_range(0, 8);
            for (int k = 0; k < 16; k++)
                smem[s][k] = (k < len) ? DW'($urandom_range(1, 4095)) : '0;
        end
        for (int k = 0; k < 16; k++) begin
            smem[5][k]  = '0;
            smem[20][k] = (k < 8) ? DW'(k * 100 + 17) : '0;
            smem[30][k] = '0;
            for (int i = 0; i < N; i++) smem[10 + i][k] = '0;
        end
        smem[5][0] = 12'd3; smem[5][1] = 12'd7; smem[5][2] = 12'd9;
        for (int i = 0; i < N; i++) smem[10 + i][0] = DW'(i + 1);

        next();
        next();
        reset = 1'b0;
        #1;
        chk_outs("reset");

        // Fill phase
        next();
        fill_req = 1'b1;
        #1;
        chk("fill_c0_we", sram_write_en, 0);
        for (int c = 1; c <= 10; c++) begin
            next();
            fill_req = 1'b0;
            req_valid = 3'b010;
            req_stream[IW +: IW] = 10'd5;
            if (c == 10) sram_write_done = 1'b1;
            #1;
            chk("fill_we", sram_write_en, 1);
            chk("fill_busy", fill_busy, 1);
            chk("fill_no_grant", req_ready, 0);
        end
        next();
        sram_write_done = 1'b0;
        req_valid = '0;
        #1;
        chk("fill_end_we", sram_write_en, 0);
        chk("fill_end_busy", fill_busy, 0);

        // Single stream 5 = {3,7,9,0}
        next();
        req_valid = 3'b001;
        req_stream[0 +: IW] = 10'd5;
        rsp_ready = 3'b111;
        #1;
        chk("single_grant", req_ready, 3'b001);
        next();
        req_valid = '0;
        #1;
        chk("single_read_en", sram_read_en, 1);
        chk("single_addr", sram_read_addr, 5);
        chk("single_c1_valid", rsp_valid, 0);
        next();
        #1;
        chk("single_c2_valid", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            next();
            #1;
            chk("single_valid", rsp_valid, 3'b001);
            chk("single_data", rsp_data, s5[k]);
            chk("single_nodone", rsp_done, 0);
        end
        next();
        #1;
        chk("single_done", rsp_done, 3'b001);
        chk("single_done_valid", rsp_valid, 0);
        next();
        #1;
        chk("single_done_pulse", rsp_done, 0);

        // Round robin from pointer 0, then fill priority
        do_reset();
        req_valid = 3'b111;
        req_stream = {10'd12, 10'd11, 10'd10};
        rsp_ready = 3'b111;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            #1;
            if (req_ready != '0) begin
                pk = pick(0, req_ready);
                chk("rr_onehot", req_ready, oh(pk));
                order.push_back(pk);
            end
            next();
        end
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk("rr_order", order[k], k % N);
        fill_req = 1'b1;
        #1;
        chk("rr_fill_wait", fill_busy, 0);
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            next();
            #1;
            done = (rsp_done != '0);
        end
        chk("rr_done_seen", done, 1);
        next();
        #1;
        chk("fill_prio_grant", req_ready, 0);
        chk("fill_prio_idle", fill_busy, 0);
        next();
        #1;
        chk("fill_prio_busy", fill_busy, 1);
        next();
        fill_req = 1'b0;
        req_valid = '0;
        sram_write_done = 1'b1;
        next();
        sram_write_done = 1'b0;
        #1;
        chk("fill_prio_end", fill_busy, 0);

        // Backpressure on an 8-word stream, requester 2
        next();
        req_valid = 3'b100;
        req_stream[2*IW +: IW] = 10'd20;
        #1;
        chk("bp_grant", req_ready, 3'b100);
        done = 1'b0;
        for (int c = 1; c < 200 && !done; c++) begin
            next();
            req_valid = '0;
            rsp_ready = (((c / 2) % 2) == 0) ? 3'b111 : 3'b011;
            #1;
            if ((rsp_valid & ~3'b100) != '0)
                chk("bp_valid_owner", rsp_valid, 3'b100);
            if (rsp_valid[2] && rsp_ready[2]) got.push_back(rsp_data);
            if (rsp_done != '0) begin
                chk("bp_done", rsp_done, 3'b100);
                done = 1'b1;
            end
        end
        chk("bp_done_seen", done, 1);
        chk("bp_count", got.size(), 8);
        for (int k = 0; k < got.size() && k < 8; k++)
            chk("bp_data", got[k], smem[20][k]);

        // Empty stream, requester 0
        rsp_ready = 3'b111;
        next();
        req_valid = 3'b001;
        req_stream[0 +: IW] = 10'd30;
        #1;
        chk("empty_grant", req_ready, 3'b001);
        for (int c = 1; c <= 3; c++) begin
            next();
            req_valid = '0;
            #1;
            chk("empty_valid", rsp_valid, 0);
            chk("empty_done", rsp_done, (c == 3) ? 3'b001 : 3'b000);
        end

        // Reset mid-READ with two words buffered, requester 1
        next();
        rsp_ready = '0;
        req_valid = 3'b010;
        req_stream[IW +: IW] = 10'd5;
        #1;
        chk("mid_grant", req_ready, 3'b010);
        for (int c = 1; c <= 4; c++) begin
            next();
            req_valid = '0;
        end
        #1;
        chk("mid_valid", rsp_valid, 3'b010);
        chk("mid_data", rsp_data, 3);
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        chk_outs("mid_reset");
        next();
        req_valid = 3'b111;
        req_stream = {10'd12, 10'd11, 10'd10};
        #1;
        chk("mid_rr_ptr0", req_ready, 3'b001);
        next();
        req_valid = '0;
        rsp_ready = 3'b111;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            next();
            #1;
            done = (rsp_done != '0);
        end
        chk("mid_after_done", done, 1);

        // Randomized traffic
        do_reset();
        p = 0;
        busy = 1'b0;
        g = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pst[i] = 0;
        end
        cyc = 0;
        anyp = 1'b0;
        while (cyc < 3000 || ((busy || anyp) && cyc < 6000)) begin
            next();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && cyc < 3000 && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pst[i] = $urandom_range(0, 15);
                end
                req_valid[i] = pend[i];
                req_stream[i*IW +: IW] = IW'(pst[i]);
            end
            rsp_ready = N'($urandom_range(0, 7));
            #1;
            pk = busy ? -1 : pick(p, req_valid);
            exp_rr = oh(pk);
            own = busy ? oh(g) : '0;
            chk("rnd_req_ready", req_ready, exp_rr);
            chk("rnd_valid_owner", rsp_valid & ~own, 0);
            if (busy && (rsp_valid & rsp_ready & own) != '0) begin
                if (expq.size() == 0) chk("rnd_extra_word", rsp_data, 0);
                else chk("rnd_data", rsp_data, expq.pop_front());
            end
            if (rsp_done != '0) begin
                chk("rnd_done", rsp_done, own);
                chk("rnd_done_left", expq.size(), 0);
                busy = 1'b0;
                p = (g + 1) % N;
            end
            if (pk >= 0) begin
                g = pk;
                busy = 1'b1;
                load_exp(pst[g]);
                pend[g] = 1'b0;
            end
            anyp = 1'b0;
            for (int i = 0; i < N; i++) anyp = anyp | pend[i];
            cyc++;
        end
        chk("rnd_quiesce", {30'd0, busy, anyp}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
